// File: rtl/fifo_stream_reader.sv
// Read-side consumer for a FIFO with a registered read port: issues reads, buffers returned
// words in a 3-entry ring and presents them as a valid/ready stream with a transfer counter.
module fifo_stream_reader #(
  parameter int data_width  = 8,
  parameter int count_width = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic [data_width-1:0]  fifo_dout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [data_width-1:0]  out_data,
  output logic [count_width-1:0] word_count,
  output logic                   busy
);

  logic [1:0]            occ;
  logic [1:0]            head;
  logic [1:0]            tail;
  logic                  inflight;
  logic [data_width-1:0] entries [3];
  logic                  capture;
  logic                  transfer;
  logic [2:0]            pending;

  function automatic logic [1:0] wrap_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reads are gated only by buffer room, never by out_ready, so the read strobe has no
  // combinational path from the downstream consumer.
  assign pending    = {1'b0, occ} + {2'b00, inflight};
  assign fifo_rd_en = !rst && !fifo_empty && (pending < 3'd3);

  assign capture   = inflight;
  assign transfer  = out_valid && out_ready;
  assign out_valid = (occ != 2'd0);
  assign out_data  = entries[head];
  assign busy      = out_valid || inflight;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ        <= 2'd0;
      head       <= 2'd0;
      tail       <= 2'd0;
      inflight   <= 1'b0;
      word_count <= '0;
      for (int i = 0; i < 3; i++) begin
        entries[i] <= '0;
      end
    end else begin
      inflight <= fifo_rd_en;
      if (capture) begin
        entries[tail] <= fifo_dout;
        tail          <= wrap_inc(tail);
      end
      if (transfer) begin
        head       <= wrap_inc(head);
        word_count <= word_count + {{(count_width-1){1'b0}}, 1'b1};
      end
      // Capture and transfer in the same cycle cancel out, including when occ is 1.
      case ({capture, transfer})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  overflow_check: assert property (@(posedge clk) disable iff (rst)
    !(capture && (occ == 2'd3) && !transfer));

endmodule
